matrix_bram_host_bridge: RTL and testbench

MATRIX_BRAM_HOST_BRIDGE -- requirements
Module: matrix_bram_host_bridge

---
 rtl/matrix_bram_host_bridge_pkg.sv | 40 ++++
 rtl/matrix_bram_host_bridge_if.sv | 47 ++++
 rtl/matrix_bram_host_bridge_sdp_bram_32.sv | 40 ++++
 rtl/matrix_bram_host_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_matrix_bram_host_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_bram_host_bridge_pkg.sv
// ---------------------------------------------------------------------------
// matrix_bram_host_bridge_pkg
// Shared matmul definitions used by the host bridge and the matrix multiply
// engine: default maximum dimensions, width helpers and the bridge state
// encoding.
// ---------------------------------------------------------------------------
package matrix_bram_host_bridge_pkg;

  // Default maximum matrix dimensions (rows of A/C, inner dim, columns of B/C)
  localparam int MAX_M_DEF = 16;
  localparam int MAX_K_DEF = 16;
  localparam int MAX_N_DEF = 16;

  // Bridge sequencing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    RUN       = 3'd3,
    DRAIN_RD  = 3'd4,
    DRAIN_OUT = 3'd5
  } state_t;

  // A dimension port must be able to hold the value MAX itself.
  function automatic int dim_w(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Word-address width of a rows x cols memory
  function automatic int addr_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/matrix_bram_host_bridge_if.sv
// ---------------------------------------------------------------------------
// matrix_bram_host_bridge_if
// Host-side bundle of the bridge: job command/status, the A/B input stream
// and the C output stream.
//   master : host (issues commands, sources s_*, sinks m_*)
//   slave  : bridge
// Parameters MW/KW/NW are the widths of cfg_M/cfg_K/cfg_N.
// ---------------------------------------------------------------------------
interface matrix_bram_host_bridge_if
  import matrix_bram_host_bridge_pkg::*;
#(
  parameter int MW = dim_w(MAX_M_DEF),
  parameter int KW = dim_w(MAX_K_DEF),
  parameter int NW = dim_w(MAX_N_DEF)
);

  // command / status
  logic          cmd_start;
  logic [MW-1:0] cfg_M;
  logic [KW-1:0] cfg_K;
  logic [NW-1:0] cfg_N;
  logic          busy;
  logic          job_done;
  logic          cfg_err;

  // input stream: A words row-major, then B words row-major
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;

  // output stream: C words row-major
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;

  modport master (
    output cmd_start, cfg_M, cfg_K, cfg_N, s_valid, s_data, m_ready,
    input  busy, job_done, cfg_err, s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  cmd_start, cfg_M, cfg_K, cfg_N, s_valid, s_data, m_ready,
    output busy, job_done, cfg_err, s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/matrix_bram_host_bridge_sdp_bram_32.sv
// ---------------------------------------------------------------------------
// sdp_bram_32
// Simple dual-port 32-bit RAM: one synchronous write port, one registered
// read port. The array itself is never reset; only the read register is.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   wr_en_i/addr/data  : write port
//   rd_addr_i          : read address, sampled every clock
//   rd_data_o          : registered read data (one-cycle latency)
// ---------------------------------------------------------------------------
module sdp_bram_32 #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write on an address collision: the old word is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/matrix_bram_host_bridge.sv
// ---------------------------------------------------------------------------
// matrix_bram_host_bridge
// Stages a matrix-multiply job for an attached engine: streams A and B into
// local memories, starts the engine, lets it write C, then streams C back.
//   clk, rst_n            : clock, async active-low reset
//   host (slave modport)  : cmd_start/cfg_M/K/N, busy, job_done, cfg_err,
//                           s_valid/s_ready/s_data, m_valid/m_ready/m_data/m_last
//   eng_start, eng_done   : engine kick (1-cycle pulse) and completion
//   eng_M/K/N             : dimensions latched at job start
//   a_addr/a_rdata        : engine read of A, one-cycle latency
//   b_addr/b_rdata        : engine read of B, one-cycle latency
//   c_we/c_addr/c_wdata   : engine write of C (honoured only in RUN)
// ---------------------------------------------------------------------------
module matrix_bram_host_bridge
  import matrix_bram_host_bridge_pkg::*;
#(
  parameter  int MAX_M = MAX_M_DEF,
  parameter  int MAX_K = MAX_K_DEF,
  parameter  int MAX_N = MAX_N_DEF,
  localparam int MW    = dim_w(MAX_M),
  localparam int KW    = dim_w(MAX_K),
  localparam int NW    = dim_w(MAX_N),
  localparam int AW_A  = addr_w(MAX_M, MAX_K),
  localparam int AW_B  = addr_w(MAX_K, MAX_N),
  localparam int AW_C  = addr_w(MAX_M, MAX_N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  matrix_bram_host_bridge_if.slave      host,
  output logic                          eng_start,
  input  logic                          eng_done,
  output logic [MW-1:0]                 eng_M,
  output logic [KW-1:0]                 eng_K,
  output logic [NW-1:0]                 eng_N,
  input  logic [AW_A-1:0]               a_addr,
  output logic [31:0]                   a_rdata,
  input  logic [AW_B-1:0]               b_addr,
  output logic [31:0]                   b_rdata,
  input  logic                          c_we,
  input  logic [AW_C-1:0]               c_addr,
  input  logic [31:0]                   c_wdata
);

  // Product width wide enough for any pair of dimensions, so M*K, K*N and
  // M*N never truncate. The word counter only needs to span the largest memory.
  localparam int PW = max3(MW + KW, KW + NW, MW + NW);
  localparam int CW = max3(AW_A, AW_B, AW_C);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] eng_m_q, eng_m_d;
  logic [KW-1:0] eng_k_q, eng_k_d;
  logic [NW-1:0] eng_n_q, eng_n_d;
  logic          eng_start_q, eng_start_d;
  logic          job_done_q, job_done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          a_we, b_we, c_we_run;
  logic [31:0]   c_rdata;

  logic [PW-1:0] prod_mk, prod_kn, prod_mn, cnt_ext;
  logic          last_mk, last_kn, last_mn;
  logic          cfg_ok;

  // ---------------------------------------------------------------------------
  // Job-size arithmetic from the latched dimensions (unsigned, full width)
  // ---------------------------------------------------------------------------
  assign prod_mk = PW'(eng_m_q) * PW'(eng_k_q);
  assign prod_kn = PW'(eng_k_q) * PW'(eng_n_q);
  assign prod_mn = PW'(eng_m_q) * PW'(eng_n_q);
  assign cnt_ext = PW'(cnt_q);

  assign last_mk = (cnt_ext == prod_mk - PW'(1));
  assign last_kn = (cnt_ext == prod_kn - PW'(1));
  assign last_mn = (cnt_ext == prod_mn - PW'(1));

  assign cfg_ok = (host.cfg_M != '0) && (host.cfg_M <= MW'(MAX_M)) &&
                  (host.cfg_K != '0) && (host.cfg_K <= KW'(MAX_K)) &&
                  (host.cfg_N != '0) && (host.cfg_N <= NW'(MAX_N));

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      eng_m_q     <= '0;
      eng_k_q     <= '0;
      eng_n_q     <= '0;
      eng_start_q <= 1'b0;
      job_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eng_m_q     <= eng_m_d;
      eng_k_q     <= eng_k_d;
      eng_n_q     <= eng_n_d;
      eng_start_q <= eng_start_d;
      job_done_q  <= job_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and memory write strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    eng_m_d     = eng_m_q;
    eng_k_d     = eng_k_q;
    eng_n_d     = eng_n_q;
    eng_start_d = 1'b0;
    job_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (host.cmd_start) begin
          if (cfg_ok) begin
            eng_m_d = host.cfg_M;
            eng_k_d = host.cfg_K;
            eng_n_d = host.cfg_N;
            cnt_d   = '0;
            state_d = LOAD_A;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      LOAD_A: begin
        if (host.s_valid) begin
          a_we = 1'b1;
          if (last_mk) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      LOAD_B: begin
        if (host.s_valid) begin
          b_we = 1'b1;
          if (last_kn) begin
            cnt_d       = '0;
            state_d     = RUN;
            // Registered so the pulse lines up with the first RUN cycle.
            eng_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      RUN: begin
        if (eng_done) begin
          cnt_d   = '0;
          state_d = DRAIN_RD;
        end
      end

      // The C read register samples cnt on this edge; m_data is valid next cycle.
      DRAIN_RD: begin
        state_d = DRAIN_OUT;
      end

      DRAIN_OUT: begin
        if (host.m_ready) begin
          if (last_mn) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = DRAIN_RD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign host.busy     = (state_q != IDLE);
  assign host.s_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign host.m_valid  = (state_q == DRAIN_OUT);
  assign host.m_last   = (state_q == DRAIN_OUT) && last_mn;
  // cnt and C are both frozen during DRAIN_OUT, so this stays stable while stalled.
  assign host.m_data   = c_rdata;
  assign host.job_done = job_done_q;
  assign host.cfg_err  = cfg_err_q;

  assign eng_start = eng_start_q;
  assign eng_M     = eng_m_q;
  assign eng_K     = eng_k_q;
  assign eng_N     = eng_n_q;

  // Engine writes are only meaningful while the engine owns C.
  assign c_we_run = c_we && (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Memories
  // ---------------------------------------------------------------------------
  sdp_bram_32 #(.DEPTH(MAX_M * MAX_K), .AW(AW_A)) u_mem_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (a_we),
    .wr_addr_i (cnt_q[AW_A-1:0]),
    .wr_data_i (host.s_data),
    .rd_addr_i (a_addr),
    .rd_data_o (a_rdata)
  );

  sdp_bram_32 #(.DEPTH(MAX_K * MAX_N), .AW(AW_B)) u_mem_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (b_we),
    .wr_addr_i (cnt_q[AW_B-1:0]),
    .wr_data_i (host.s_data),
    .rd_addr_i (b_addr),
    .rd_data_o (b_rdata)
  );

  sdp_bram_32 #(.DEPTH(MAX_M * MAX_N), .AW(AW_C)) u_mem_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (c_we_run),
    .wr_addr_i (c_addr),
    .wr_data_i (c_wdata),
    .rd_addr_i (cnt_q[AW_C-1:0]),
    .rd_data_o (c_rdata)
  );

endmodule

// File: tb/tb_matrix_bram_host_bridge.sv
// ---------------------------------------------------------------------------
// tb_matrix_bram_host_bridge
// Drives jobs into the bridge, attaches a behavioural single-precision
// matmul engine, and scoreboards the C stream against hand-computed words.
// ---------------------------------------------------------------------------
module tb_matrix_bram_host_bridge;
  import matrix_bram_host_bridge_pkg::*;

  localparam int MW = 5;
  localparam int KW = 5;
  localparam int NW = 5;
  localparam int AW = 8;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_bram_host_bridge_if #(.MW(MW), .KW(KW), .NW(NW)) host ();

  logic          eng_start;
  logic          eng_done;
  logic [MW-1:0] eng_M;
  logic [KW-1:0] eng_K;
  logic [NW-1:0] eng_N;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [31:0]   a_rdata, b_rdata, c_wdata;
  logic          c_we;

  matrix_bram_host_bridge #(.MAX_M(16), .MAX_K(16), .MAX_N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_M     (eng_M),
    .eng_K     (eng_K),
    .eng_N     (eng_N),
    .a_addr    (a_addr),
    .a_rdata   (a_rdata),
    .b_addr    (b_addr),
    .b_rdata   (b_rdata),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata)
  );

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   jd_cnt = 0;
  int   ce_cnt = 0;
  int   es_cnt = 0;
  int   rdy_mode = 0;
  logic poke_req = 1'b0;
  logic [AW-1:0] poke_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // single-precision <-> real (normals and zero only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural engine (also carries out stray C write requests)
  // ---------------------------------------------------------------------------
  task automatic run_engine();
    real acc;
    int  m, k, n;
    m = int'(eng_M);
    k = int'(eng_K);
    n = int'(eng_N);
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0.0;
        for (int x = 0; x < k; x++) begin
          a_addr = AW'(i * k + x);
          b_addr = AW'(x * n + j);
          @(posedge clk); #1;
          acc = acc + f2r(a_rdata) * f2r(b_rdata);
        end
        c_we    = 1'b1;
        c_addr  = AW'(i * n + j);
        c_wdata = r2f(acc);
        @(posedge clk); #1;
        c_we = 1'b0;
      end
    end
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
  endtask

  initial begin
    eng_done = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    c_wdata  = '0;
    c_we     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (poke_req) begin
        c_we    = 1'b1;
        c_addr  = poke_addr;
        c_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        c_we     = 1'b0;
        poke_req = 1'b0;
      end else if (eng_start && rst_n) begin
        run_engine();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // m_ready pattern: 0 = always ready, 1 = toggle, 2 = ready one cycle in three
  // ---------------------------------------------------------------------------
  initial begin
    int ph = 0;
    host.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      case (rdy_mode)
        1:       host.m_ready = ~host.m_ready;
        2:       host.m_ready = ((ph % 3) == 0);
        default: host.m_ready = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic        stall_prev;
    logic [31:0] stall_data;
    exp_t        e;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      if (host.job_done) jd_cnt++;
      if (host.cfg_err)  ce_cnt++;
      if (eng_start)     es_cnt++;
      if (host.m_valid) begin
        if (stall_prev) check("m_data_stable", host.m_data, stall_data);
        if (host.m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h expected no word", host.m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", host.m_data, e.data);
            check("m_last", 32'(host.m_last), 32'(e.last));
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_data = host.m_data;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic start_job(input int m, input int k, input int n);
    host.cfg_M     = MW'(m);
    host.cfg_K     = KW'(k);
    host.cfg_N     = NW'(n);
    host.cmd_start = 1'b1;
    @(posedge clk); #1;
    host.cmd_start = 1'b0;
  endtask

  task automatic send_words(input wq_t w, input int cnt);
    int t;
    for (int i = 0; i < cnt; i++) begin
      host.s_valid = 1'b1;
      host.s_data  = w[i];
      t = 0;
      @(negedge clk);
      while (!host.s_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        timeout_fail("s_ready");
        host.s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    host.s_valid = 1'b0;
  endtask

  task automatic begin_job(input int m, input int k, input int n,
                           input wq_t a, input wq_t b, input wq_t c, input bit poke_load);
    for (int i = 0; i < m * n; i++) begin
      exp_q.push_back('{data: c[i], last: (i == m * n - 1)});
    end
    start_job(m, k, n);
    if (poke_load) begin
      poke_addr = '0;
      poke_req  = 1'b1;
    end
    send_words(a, m * k);
    send_words(b, k * n);
  endtask

  task automatic finish_job(input int jd0, input int es0);
    int t = 0;
    while (jd_cnt == jd0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) timeout_fail("job_done");
    repeat (3) @(negedge clk);
    check("job_done_pulses", 32'(jd_cnt - jd0), 32'd1);
    check("eng_start_pulses", 32'(es_cnt - es0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic cfg_err_case(input int m, input int k, input int n);
    int ce0 = ce_cnt;
    start_job(m, k, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cfg_busy", 32'(host.busy), 32'd0);
      check("cfg_s_ready", 32'(host.s_ready), 32'd0);
    end
    check("cfg_err_pulses", 32'(ce_cnt - ce0), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    wq_t a_v, b_v, c_v;
    int  jd0, es0, t;

    host.cmd_start = 1'b0;
    host.cfg_M     = '0;
    host.cfg_K     = '0;
    host.cfg_N     = '0;
    host.s_valid   = 1'b0;
    host.s_data    = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({host.busy, host.s_ready, host.m_valid, host.m_last,
                           eng_start, host.job_done, host.cfg_err}), 32'd0);
    check("rst_m_data", host.m_data, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_dims", 32'({eng_M, eng_K, eng_N}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2x2, B = identity, always ready
    a_v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    b_v = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    c_v = a_v;
    jd0 = jd_cnt; es0 = es_cnt;
    begin_job(2, 2, 2, a_v, b_v, c_v, 1'b0);
    finish_job(jd0, es0);

    // same job, m_ready toggling; a C write during the drain must be ignored
    rdy_mode = 1;
    jd0 = jd_cnt; es0 = es_cnt;
    begin_job(2, 2, 2, a_v, b_v, c_v, 1'b0);
    t = 0;
    while (!host.m_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout_fail("m_valid");
    poke_addr = AW'(3);
    poke_req  = 1'b1;
    finish_job(jd0, es0);
    rdy_mode = 0;

    // bad dimensions
    cfg_err_case(2, 0, 2);
    cfg_err_case(17, 2, 2);

    // DEADBEEF poked during LOAD_A; cmd_start during RUN ignored
    a_v = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h40400000};
    b_v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    c_v = '{32'h40A00000, 32'h41000000, 32'h41100000, 32'h41400000};
    jd0 = jd_cnt; es0 = es_cnt;
    begin_job(2, 2, 2, a_v, b_v, c_v, 1'b1);
    t = 0;
    while (es_cnt == es0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout_fail("eng_start");
    start_job(1, 1, 1);
    check("run_eng_M_held", 32'(eng_M), 32'd2);
    finish_job(jd0, es0);

    // non-square 2x1x3, sparse m_ready
    rdy_mode = 2;
    a_v = '{32'h3F800000, 32'h40000000};
    b_v = '{32'h3F800000, 32'h40000000, 32'h40400000};
    c_v = '{32'h3F800000, 32'h40000000, 32'h40400000,
            32'h40000000, 32'h40800000, 32'h40C00000};
    jd0 = jd_cnt; es0 = es_cnt;
    begin_job(2, 1, 3, a_v, b_v, c_v, 1'b0);
    finish_job(jd0, es0);
    rdy_mode = 0;

    // reset after 3 of the B beats, then a fresh 1x1x1 job
    a_v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    b_v = '{32'h3F800000, 32'h00000000, 32'h00000000};
    start_job(2, 2, 2);
    send_words(a_v, 4);
    send_words(b_v, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(host.busy), 32'd0);
    check("midrst_s_ready", 32'(host.s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_v = '{32'h40000000};
    b_v = '{32'h40400000};
    c_v = '{32'h40C00000};
    jd0 = jd_cnt; es0 = es_cnt;
    begin_job(1, 1, 1, a_v, b_v, c_v, 1'b0);
    finish_job(jd0, es0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
